// File: rtl/attention_coef_packer.sv
// Attention coefficient packer: scores each node of a subgraph against its source
// (LeakyReLU, scale, saturate) and packs the coefficients into one word for softmax.
module attention_coef_packer #(
  parameter int MAX_NODES      = 16,
  parameter int WH_DATA_WIDTH  = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_NODE_WIDTH = 4,
  parameter int LRELU_SHIFT    = 2,
  parameter int COEF_SHIFT     = 8
) (
  input  logic                                             i_clk,
  input  logic                                             i_rst,
  input  logic                                             i_a_wr_en,
  input  logic [$clog2(2*MAX_NODES)-1:0]                   i_a_addr,
  input  logic [DATA_WIDTH-1:0]                            i_a_data,
  input  logic                                             i_wh_valid,
  output logic                                             o_wh_ready,
  input  logic [MAX_NODES*WH_DATA_WIDTH+NUM_NODE_WIDTH:0]  i_wh_data,
  output logic                                             o_coef_valid,
  input  logic                                             i_coef_ready,
  output logic [MAX_NODES*DATA_WIDTH+NUM_NODE_WIDTH-1:0]   o_coef_data,
  output logic                                             o_proto_err
);

  localparam int WH_WIDTH = MAX_NODES*WH_DATA_WIDTH + NUM_NODE_WIDTH + 1;
  localparam int COEF_W   = MAX_NODES*DATA_WIDTH;
  localparam int PROD_W   = WH_DATA_WIDTH + DATA_WIDTH;
  localparam int DOT_W    = PROD_W + $clog2(MAX_NODES);
  localparam int E_W      = DOT_W + 1;
  localparam int CNT_W    = NUM_NODE_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_WAIT_SRC = 2'd0,
    ST_ACCUM    = 2'd1,
    ST_EMIT     = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic signed [DATA_WIDTH-1:0]   r_a [2*MAX_NODES];
  logic                           r_wh_ready;
  logic                           r_coef_valid;
  logic                           r_proto_err;
  logic signed [DOT_W-1:0]        r_s;
  logic [NUM_NODE_WIDTH-1:0]      r_num;
  logic [CNT_W-1:0]               r_nodes;
  logic [CNT_W-1:0]               r_count;
  logic [DATA_WIDTH-1:0]          r_slot [MAX_NODES];

  logic                           w_flag;
  logic [NUM_NODE_WIDTH-1:0]      w_num;
  logic [CNT_W-1:0]               w_src_nodes;
  logic                           w_accept;
  logic                           w_src_acc;
  logic                           w_nbr_acc;
  logic                           w_err;
  logic signed [WH_DATA_WIDTH-1:0] w_wh_el;
  logic signed [PROD_W-1:0]       w_prod_lo;
  logic signed [PROD_W-1:0]       w_prod_hi;
  logic signed [DOT_W-1:0]        w_dot_lo;
  logic signed [DOT_W-1:0]        w_dot_hi;
  logic signed [DOT_W-1:0]        w_base;
  logic signed [E_W-1:0]          w_e;
  logic signed [E_W-1:0]          w_lrelu;
  logic signed [E_W-1:0]          w_scaled;
  logic [DATA_WIDTH-1:0]          w_coef;
  logic [COEF_W+NUM_NODE_WIDTH-1:0] w_coef_data;

  // Clamp to the signed coefficient range: it fits when all bits above the sign agree.
  function automatic logic [DATA_WIDTH-1:0] sat_coef(input logic signed [E_W-1:0] v);
    if ((&v[E_W-1:DATA_WIDTH-1]) || (~|v[E_W-1:DATA_WIDTH-1])) begin
      return v[DATA_WIDTH-1:0];
    end else if (v[E_W-1]) begin
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  endfunction

  assign w_flag      = i_wh_data[0];
  assign w_num       = i_wh_data[NUM_NODE_WIDTH:1];
  assign w_src_nodes = (w_num == {NUM_NODE_WIDTH{1'b0}}) ? CNT_W'(MAX_NODES) : {1'b0, w_num};
  assign w_accept    = i_wh_valid & r_wh_ready;

  // a[i] weights Wh_(i+1) in the source half, a[MAX_NODES+i] in the node half.
  always_comb begin
    w_dot_lo  = '0;
    w_dot_hi  = '0;
    w_wh_el   = '0;
    w_prod_lo = '0;
    w_prod_hi = '0;
    for (int i = 0; i < MAX_NODES; i++) begin
      w_wh_el   = i_wh_data[WH_WIDTH-1-i*WH_DATA_WIDTH -: WH_DATA_WIDTH];
      w_prod_lo = PROD_W'(w_wh_el) * PROD_W'(r_a[i]);
      w_prod_hi = PROD_W'(w_wh_el) * PROD_W'(r_a[MAX_NODES+i]);
      w_dot_lo  = w_dot_lo + DOT_W'(w_prod_lo);
      w_dot_hi  = w_dot_hi + DOT_W'(w_prod_hi);
    end
  end

  // A source word scores against its own fresh s; other nodes use the latched s.
  always_comb begin
    w_base   = w_flag ? w_dot_lo : r_s;
    w_e      = E_W'(w_base) + E_W'(w_dot_hi);
    w_lrelu  = w_e[E_W-1] ? (w_e >>> LRELU_SHIFT) : w_e;
    w_scaled = w_lrelu >>> COEF_SHIFT;
    w_coef   = sat_coef(w_scaled);
  end

  // Next-state and accept decode.
  always_comb begin
    w_state_nxt = r_state;
    w_src_acc   = 1'b0;
    w_nbr_acc   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_WAIT_SRC: begin
        if (w_accept) begin
          if (w_flag) begin
            w_src_acc   = 1'b1;
            w_state_nxt = (w_src_nodes == CNT_W'(1)) ? ST_EMIT : ST_ACCUM;
          end else begin
            w_err = 1'b1;
          end
        end else begin
          w_state_nxt = ST_WAIT_SRC;
        end
      end
      ST_ACCUM: begin
        if (w_accept) begin
          if (w_flag) begin
            // New source mid-subgraph: the partial subgraph is abandoned.
            w_err       = 1'b1;
            w_src_acc   = 1'b1;
            w_state_nxt = (w_src_nodes == CNT_W'(1)) ? ST_EMIT : ST_ACCUM;
          end else begin
            w_nbr_acc   = 1'b1;
            w_state_nxt = ((r_count + CNT_W'(1)) == r_nodes) ? ST_EMIT : ST_ACCUM;
          end
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_EMIT: begin
        if (i_coef_ready) begin
          w_state_nxt = ST_WAIT_SRC;
        end else begin
          w_state_nxt = ST_EMIT;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_SRC;
      end
    endcase
  end

  // State register and handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_WAIT_SRC;
      r_wh_ready   <= 1'b1;
      r_coef_valid <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wh_ready   <= (w_state_nxt != ST_EMIT);
      r_coef_valid <= (w_state_nxt == ST_EMIT);
      if (w_err) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // a-vector register file.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 2*MAX_NODES; i++) begin
        r_a[i] <= '0;
      end
    end else if (i_a_wr_en) begin
      r_a[i_a_addr] <= i_a_data;
    end
  end

  // Subgraph context and coefficient slots.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s     <= '0;
      r_num   <= '0;
      r_nodes <= '0;
      r_count <= '0;
      for (int i = 0; i < MAX_NODES; i++) begin
        r_slot[i] <= '0;
      end
    end else if (w_src_acc) begin
      r_s     <= w_dot_lo;
      r_num   <= w_num;
      r_nodes <= w_src_nodes;
      r_count <= CNT_W'(1);
      for (int i = 1; i < MAX_NODES; i++) begin
        r_slot[i] <= '0;
      end
      r_slot[0] <= w_coef;
    end else if (w_nbr_acc) begin
      r_slot[r_count[NUM_NODE_WIDTH-1:0]] <= w_coef;
      r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_coef_data = '0;
    for (int i = 0; i < MAX_NODES; i++) begin
      w_coef_data[COEF_W+NUM_NODE_WIDTH-1-i*DATA_WIDTH -: DATA_WIDTH] = r_slot[i];
    end
    w_coef_data[NUM_NODE_WIDTH-1:0] = r_num;
  end

  assign o_wh_ready   = r_wh_ready;
  assign o_coef_valid = r_coef_valid;
  assign o_coef_data  = w_coef_data;
  assign o_proto_err  = r_proto_err;

endmodule

// File: tb/tb_attention_coef_packer.sv
// Directed, table-driven bench for attention_coef_packer with hand-computed coefficients.
module tb_attention_coef_packer;

  logic         clk = 1'b0;
  logic         i_rst;
  logic         i_a_wr_en;
  logic [4:0]   i_a_addr;
  logic [7:0]   i_a_data;
  logic         i_wh_valid;
  logic         o_wh_ready;
  logic [196:0] i_wh_data;
  logic         o_coef_valid;
  logic         i_coef_ready;
  logic [131:0] o_coef_data;
  logic         o_proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  attention_coef_packer dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_a_wr_en   (i_a_wr_en),
    .i_a_addr    (i_a_addr),
    .i_a_data    (i_a_data),
    .i_wh_valid  (i_wh_valid),
    .o_wh_ready  (o_wh_ready),
    .i_wh_data   (i_wh_data),
    .o_coef_valid(o_coef_valid),
    .i_coef_ready(i_coef_ready),
    .o_coef_data (o_coef_data),
    .o_proto_err (o_proto_err)
  );

  typedef struct {
    logic signed [7:0]  a_lo;
    logic signed [7:0]  a_hi;
    logic signed [11:0] wh_src;
    logic signed [11:0] wh_nbr;
    int                 n;
    logic [7:0]         c_src;
    logic [7:0]         c_nbr;
  } vec_t;

  vec_t         vecs [7];
  int           nn;
  logic [131:0] exp_word;
  logic [7:0]   slot_val;

  task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [196:0] mk_wh(input logic signed [11:0] v, input logic [3:0] num,
                                         input logic flag);
    logic [196:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) w[196-12*k -: 12] = v;
    w[4:1] = num;
    w[0]   = flag;
    return w;
  endfunction

  function automatic logic [131:0] mk_coef(input logic [3:0] num, input int nodes,
                                           input logic [7:0] c1, input logic [7:0] cn);
    logic [131:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) w[131 -: 8] = c1;
      else if (k < nodes) w[131-8*k -: 8] = cn;
    end
    w[3:0] = num;
    return w;
  endfunction

  task automatic set_a(input logic signed [7:0] lo, input logic signed [7:0] hi);
    for (int i = 0; i < 32; i++) begin
      i_a_wr_en = 1'b1;
      i_a_addr  = 5'(i);
      i_a_data  = (i < 16) ? lo : hi;
      tick();
    end
    i_a_wr_en = 1'b0;
  endtask

  task automatic send(input logic [196:0] w);
    int b;
    b          = 0;
    i_wh_data  = w;
    i_wh_valid = 1'b1;
    while (!o_wh_ready && b < 20) begin
      tick();
      b++;
    end
    if (!o_wh_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: got wh_ready=0 after %0d cycles expected 1", b);
    end
    tick();
    i_wh_valid = 1'b0;
  endtask

  // Called right after the last node edge: coef_valid must already be high.
  task automatic finish_coef(input string name, input logic [131:0] exp);
    chk({name, "_latency"}, o_coef_valid, 1'b1);
    chk({name, "_data"}, o_coef_data, exp);
    i_coef_ready = 1'b1;
    tick();
    i_coef_ready = 1'b0;
    chk({name, "_valid_drop"}, o_coef_valid, 1'b0);
    chk({name, "_ready_back"}, o_wh_ready, 1'b1);
  endtask

  task automatic reset_pulse();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'sd1,  8'sd1,  12'sd1,    12'sd1,   1, 8'h00, 8'h00};
    vecs[1] = '{8'sd4,  8'sd4,  12'sd8,    12'sd8,   3, 8'h04, 8'h04};
    vecs[2] = '{-8'sd8, -8'sd8, 12'sd127,  12'sd127, 2, 8'hE0, 8'hE0};
    vecs[3] = '{8'sd127, 8'sd127, 12'sd127, 12'sd127, 2, 8'h7F, 8'h7F};
    vecs[4] = '{8'h80,  8'h80,  12'sd127,  12'sd127, 2, 8'h80, 8'h80};
    vecs[5] = '{8'sd1,  8'sd2,  12'sd100,  12'sd10,  5, 8'h12, 8'h07};
    vecs[6] = '{8'sd2,  -8'sd3, -12'sd100, 12'sd200, 4, 8'h06, 8'hF3};

    i_rst = 1'b1; i_a_wr_en = 1'b0; i_a_addr = '0; i_a_data = '0;
    i_wh_valid = 1'b0; i_wh_data = '0; i_coef_ready = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    chk("rst_wh_ready", o_wh_ready, 1'b1);
    chk("rst_coef_valid", o_coef_valid, 1'b0);
    chk("rst_coef_data", o_coef_data, 132'd0);
    chk("rst_proto_err", o_proto_err, 1'b0);

    for (int v = 0; v < 7; v++) begin
      set_a(vecs[v].a_lo, vecs[v].a_hi);
      nn = vecs[v].n;
      send(mk_wh(vecs[v].wh_src, nn[3:0], 1'b1));
      for (int j = 1; j < nn; j++) begin
        chk($sformatf("vec%0d_no_early_valid", v), o_coef_valid, 1'b0);
        send(mk_wh(vecs[v].wh_nbr, 4'd7, 1'b0));
      end
      finish_coef($sformatf("vec%0d", v), mk_coef(nn[3:0], nn, vecs[v].c_src, vecs[v].c_nbr));
    end
    chk("table_proto_err", o_proto_err, 1'b0);

    // N=0 encodes 16 nodes; node j carries Wh=8j so its coefficient is j.
    set_a(8'sd1, 8'sd2);
    send(mk_wh(12'sd8, 4'd0, 1'b1));
    for (int j = 2; j <= 16; j++) send(mk_wh(12'(8*j), 4'd0, 1'b0));
    exp_word = '0;
    for (int k = 0; k < 16; k++) begin
      slot_val = 8'(k + 1);
      exp_word[131-8*k -: 8] = slot_val;
    end
    chk("n16_valid", o_coef_valid, 1'b1);
    i_wh_data  = mk_wh(12'sd8, 4'd1, 1'b1);
    i_wh_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("n16_hold%0d_data", c), o_coef_data, exp_word);
      chk($sformatf("n16_hold%0d_wh_ready", c), o_wh_ready, 1'b0);
      tick();
    end
    i_wh_valid = 1'b0;
    finish_coef("n16", exp_word);

    // Stray neighbour word, then a new source cuts a 4-node subgraph short.
    send(mk_wh(12'sd8, 4'd2, 1'b0));
    chk("perr_set", o_proto_err, 1'b1);
    chk("perr_stay_wait_valid", o_coef_valid, 1'b0);
    send(mk_wh(12'sd8, 4'd4, 1'b1));
    send(mk_wh(12'sd40, 4'd0, 1'b0));
    send(mk_wh(12'sd24, 4'd2, 1'b1));
    chk("perr_no_emit", o_coef_valid, 1'b0);
    send(mk_wh(12'sd80, 4'd0, 1'b0));
    finish_coef("perr_second", mk_coef(4'd2, 2, 8'h04, 8'h0B));
    chk("perr_sticky", o_proto_err, 1'b1);

    // Reset mid-ACCUM, then during EMIT; a-vector is cleared too.
    send(mk_wh(12'sd8, 4'd3, 1'b1));
    send(mk_wh(12'sd8, 4'd0, 1'b0));
    reset_pulse();
    chk("rst_acc_wh_ready", o_wh_ready, 1'b1);
    chk("rst_acc_valid", o_coef_valid, 1'b0);
    chk("rst_acc_data", o_coef_data, 132'd0);
    chk("rst_acc_perr", o_proto_err, 1'b0);
    set_a(8'sd1, 8'sd2);
    send(mk_wh(12'sd8, 4'd2, 1'b1));
    send(mk_wh(12'sd24, 4'd0, 1'b0));
    chk("rst_emit_pre_data", o_coef_data, mk_coef(4'd2, 2, 8'h01, 8'h03));
    reset_pulse();
    chk("rst_emit_wh_ready", o_wh_ready, 1'b1);
    chk("rst_emit_valid", o_coef_valid, 1'b0);
    chk("rst_emit_data", o_coef_data, 132'd0);
    set_a(8'sd1, 8'sd2);
    send(mk_wh(12'sd16, 4'd1, 1'b1));
    finish_coef("post_rst", mk_coef(4'd1, 1, 8'h03, 8'h00));
    chk("post_rst_perr", o_proto_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
